// File: rtl/eth_pkt_fifo.sv
// eth_pkt_fifo: store-and-forward packet FIFO from a MAC RX stream to a TX stream.
// Whole frames are buffered. Only frames that end with tuser=1 and fit are made
// visible to the read side. Errored, oversize and overflowing frames are rewound away.
// The write side has no back-pressure. The read side is a one-beat prefetch feeding
// an output register, so it sustains one beat per cycle.
module eth_pkt_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk156,
  input  logic                  eth_rst,
  input  logic                  s_axis_rx_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rx_tkeep,
  input  logic                  s_axis_rx_tlast,
  input  logic                  s_axis_rx_tuser,
  output logic                  m_axis_tx_tvalid,
  input  logic                  m_axis_tx_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
  output logic                  m_axis_tx_tlast,
  output logic                  m_axis_tx_tuser,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic [ADDR_WIDTH:0]   fifo_level
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;
  // The pointer difference that means every RAM entry is occupied.
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    STORE    = 2'd2,
    DROP     = 2'd3
  } wr_state_e;

  wr_state_e state_q, state_d;

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] used_lvl;
  logic                full;

  logic                wr_en;
  logic                pkt_inc;
  logic                drop_inc;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   pf_word_q;
  logic                pf_vld_q, pf_vld_d;
  logic [WORD_W-1:0]   out_word_q, out_word_d;
  logic                out_vld_q, out_vld_d;
  logic                has_data;
  logic                out_ready;
  logic                pf_move;
  logic                ram_rd;

  // The occupancy covers committed and uncommitted beats. It is built from
  // registered pointers only, so no input can reach it combinationally.
  assign used_lvl   = wr_ptr_q - rd_ptr_q;
  assign full       = (used_lvl == FULL_LVL);
  assign fifo_level = used_lvl;

  // ---------------------------------------------------------------- write FSM

  // State register for the write-side frame FSM.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) state_q <= WAIT_GAP;
    else         state_q <= state_d;
  end

  // Next state: any tlast resolves the frame back to IDLE, and an overflow
  // in the middle of a frame discards the rest of it in DROP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_GAP: if (!s_axis_rx_tvalid) state_d = IDLE;
      IDLE, STORE: begin
        if (s_axis_rx_tvalid) begin
          if (s_axis_rx_tlast) state_d = IDLE;
          else if (full)       state_d = DROP;
          else                 state_d = STORE;
        end
      end
      DROP: if (s_axis_rx_tvalid && s_axis_rx_tlast) state_d = IDLE;
      default: state_d = WAIT_GAP;
    endcase
  end

  // Write-side actions. Both overflow and a bad tlast rewind wr_ptr to the
  // last commit point. A good tlast moves the commit point up to include the frame.
  always_comb begin
    wr_en        = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    unique case (state_q)
      IDLE, STORE: begin
        if (s_axis_rx_tvalid) begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = s_axis_rx_tlast;
          end else if (s_axis_rx_tlast && !s_axis_rx_tuser) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_rx_tlast) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              pkt_inc      = 1'b1;
            end
          end
        end
      end
      DROP:    drop_inc = s_axis_rx_tvalid && s_axis_rx_tlast;
      default: ;
    endcase
  end

  // pkt_cnt wraps, while drop_cnt holds at all-ones.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + {31'd0, pkt_inc};
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Write pointers and frame counters.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

  // ---------------------------------------------------------------- storage

  // Frame RAM with a registered read port. That read register is the prefetch
  // stage, so it only loads when the prefetch slot is free or being drained.
  always_ff @(posedge clk156) begin
    if (wr_en)  mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata};
    if (ram_rd) pf_word_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // ---------------------------------------------------------------- read side

  // Reads are limited to the committed range. The output register refills
  // whenever it is empty or being accepted, which gives full rate with no
  // bubbles and keeps the word stable while the sink stalls.
  always_comb begin
    has_data   = (rd_ptr_q != commit_ptr_q);
    out_ready  = !out_vld_q || m_axis_tx_tready;
    pf_move    = pf_vld_q && out_ready;
    ram_rd     = has_data && (!pf_vld_q || out_ready);
    rd_ptr_d   = rd_ptr_q;
    if (ram_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    pf_vld_d   = pf_vld_q;
    if (ram_rd)       pf_vld_d = 1'b1;
    else if (pf_move) pf_vld_d = 1'b0;
    out_vld_d  = out_ready ? pf_vld_q : out_vld_q;
    out_word_d = pf_move ? pf_word_q : out_word_q;
  end

  // Read pointer, prefetch valid and output register.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      rd_ptr_q   <= '0;
      pf_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      pf_vld_q   <= pf_vld_d;
      out_vld_q  <= out_vld_d;
      out_word_q <= out_word_d;
    end
  end

  assign m_axis_tx_tvalid = out_vld_q;
  assign {m_axis_tx_tlast, m_axis_tx_tkeep, m_axis_tx_tdata} = out_word_q;
  assign m_axis_tx_tuser  = 1'b0;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Bench for eth_pkt_fifo. It drives random frames and tracks a queue of the beats
// that should come out. Whole frames are delivered or dropped using the frame rules
// (good tlast, fits in free space). DUT A uses the default depth. DUT B uses
// ADDR_WIDTH=4 and covers the oversize-frame case.
module tb_eth_pkt_fifo;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int AWA = 9;
  localparam int AWB = 4;
  localparam int DEPTH_A = 1 << AWA;
  localparam int DEPTH_B = 1 << AWB;

  logic clk156 = 1'b0;
  logic eth_rst = 1'b0;
  always #5 clk156 = ~clk156;

  logic          rx_vld = 1'b0, rx_last = 1'b0, rx_user = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [KW-1:0] rx_keep = '0;
  logic          sel_b = 1'b0;
  logic          rnd_rdy = 1'b0, rdy_fix = 1'b1, rnd_bit = 1'b0, b_tready = 1'b0;
  logic          a_vld_in, b_vld_in, a_tready;

  assign a_vld_in = rx_vld & ~sel_b;
  assign b_vld_in = rx_vld & sel_b;
  assign a_tready = rnd_rdy ? rnd_bit : rdy_fix;

  logic          a_tvalid, a_tlast, a_tuser, b_tvalid, b_tlast, b_tuser;
  logic [DW-1:0] a_tdata, b_tdata;
  logic [KW-1:0] a_tkeep, b_tkeep;
  logic [31:0]   a_pkt_cnt, b_pkt_cnt;
  logic [15:0]   a_drop_cnt, b_drop_cnt;
  logic [AWA:0]  a_level;
  logic [AWB:0]  b_level;

  eth_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AWA)) dut_a (
    .clk156(clk156), .eth_rst(eth_rst),
    .s_axis_rx_tvalid(a_vld_in), .s_axis_rx_tdata(rx_data), .s_axis_rx_tkeep(rx_keep),
    .s_axis_rx_tlast(rx_last), .s_axis_rx_tuser(rx_user),
    .m_axis_tx_tvalid(a_tvalid), .m_axis_tx_tready(a_tready), .m_axis_tx_tdata(a_tdata),
    .m_axis_tx_tkeep(a_tkeep), .m_axis_tx_tlast(a_tlast), .m_axis_tx_tuser(a_tuser),
    .pkt_cnt(a_pkt_cnt), .drop_cnt(a_drop_cnt), .fifo_level(a_level)
  );

  eth_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AWB)) dut_b (
    .clk156(clk156), .eth_rst(eth_rst),
    .s_axis_rx_tvalid(b_vld_in), .s_axis_rx_tdata(rx_data), .s_axis_rx_tkeep(rx_keep),
    .s_axis_rx_tlast(rx_last), .s_axis_rx_tuser(rx_user),
    .m_axis_tx_tvalid(b_tvalid), .m_axis_tx_tready(b_tready), .m_axis_tx_tdata(b_tdata),
    .m_axis_tx_tkeep(b_tkeep), .m_axis_tx_tlast(b_tlast), .m_axis_tx_tuser(b_tuser),
    .pkt_cnt(b_pkt_cnt), .drop_cnt(b_drop_cnt), .fifo_level(b_level)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the beats expected at the output, in order, plus frame counts.
  logic [DW+KW:0] exp_q[$];
  int exp_pkt = 0;
  int exp_drop = 0;

  int cyc = 0;
  int commit_cyc = -1;
  int rise_cyc = -1;
  int acc_cyc[$];

  always @(posedge clk156) cyc <= cyc + 1;

  always @(posedge clk156) begin
    #1;
    rnd_bit = $urandom_range(0, 1);
  end

  // Monitor for DUT A: scoreboard of accepted beats and a stability check while stalled.
  logic [DW+KW:0] prev_w = '0;
  bit prev_stall = 0;
  bit prev_vld = 0;
  always @(negedge clk156) begin
    if (eth_rst) begin
      prev_stall = 0;
      prev_vld   = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", a_tvalid, 1'b1);
        chk("hold_data", {a_tlast, a_tkeep, a_tdata}, prev_w);
      end
      if (a_tvalid && !prev_vld && rise_cyc < 0) rise_cyc = cyc;
      if (a_tvalid && a_tready) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1'b1, 1'b0);
        else chk("beat", {a_tlast, a_tkeep, a_tdata}, exp_q.pop_front());
        acc_cyc.push_back(cyc);
      end
      prev_stall = a_tvalid && !a_tready;
      prev_w     = {a_tlast, a_tkeep, a_tdata};
      prev_vld   = a_tvalid;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
    rx_data = d; rx_keep = k; rx_last = l; rx_user = u; rx_vld = 1'b1;
    @(posedge clk156);
    #1;
    if (l && u && !sel_b && commit_cyc < 0) commit_cyc = cyc;
    rx_vld = 1'b0; rx_last = 1'b0;
  endtask

  // Build a random frame. The model delivers it only if it is good and fits the free space.
  task automatic send_frame(input int len, input bit good, input int depth, input bit gaps);
    logic [DW+KW:0] f[$];
    logic           lst;
    logic [KW-1:0]  k;
    bit             deliver;
    for (int i = 0; i < len; i++) begin
      lst = (i == len - 1);
      k   = lst ? ({KW{1'b1}} >> $urandom_range(0, KW - 1)) : {KW{1'b1}};
      f.push_back({lst, k, $urandom, $urandom});
    end
    deliver = good && (len <= depth - exp_q.size());
    if (deliver) begin
      foreach (f[i]) exp_q.push_back(f[i]);
      exp_pkt++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) idle(1);
      send_beat(f[i][DW-1:0], f[i][DW+KW-1:DW], f[i][DW+KW], good);
    end
  endtask

  task automatic do_reset();
    eth_rst = 1'b1;
    rx_vld = 1'b0;
    exp_q.delete();
    acc_cyc.delete();
    exp_pkt = 0;
    exp_drop = 0;
    idle(2);
    eth_rst = 1'b0;
    idle(3);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic chk_a_counts(input string tag);
    chk({tag, "_pkt"}, a_pkt_cnt, exp_pkt);
    chk({tag, "_drop"}, a_drop_cnt, exp_drop);
    chk({tag, "_level"}, a_level, 0);
    chk({tag, "_vld"}, a_tvalid, 1'b0);
  endtask

  initial begin
    int len, guard;
    // Reset values
    #1 eth_rst = 1'b1;
    @(posedge clk156);
    #1;
    chk("rst_tvalid", a_tvalid, 1'b0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_tkeep", a_tkeep, 0);
    chk("rst_tlast", a_tlast, 1'b0);
    chk("rst_tuser", a_tuser, 1'b0);
    chk("rst_pkt", a_pkt_cnt, 0);
    chk("rst_drop", a_drop_cnt, 0);
    chk("rst_level", a_level, 0);
    chk("rst_b_tvalid", b_tvalid, 1'b0);
    chk("rst_b_tuser", b_tuser, 1'b0);
    do_reset();

    // Three back-to-back good frames, tready=1
    rdy_fix = 1'b1;
    send_frame(8, 1, DEPTH_A, 0);
    send_frame(1, 1, DEPTH_A, 0);
    send_frame(5, 1, DEPTH_A, 0);
    chk("t1_pkt_now", a_pkt_cnt, 3);
    wait_drain(200);
    chk("t1_latency", rise_cyc - commit_cyc, 2);
    chk("t1_beats_out", acc_cyc.size(), 14);
    if (acc_cyc.size() >= 14) begin
      chk("t1_no_gap", acc_cyc[13] - acc_cyc[0], 13);
      chk("t1_first_at_rise", acc_cyc[0], rise_cyc);
    end
    chk_a_counts("t1");

    // A bad frame is rewound, and the good frame after it passes
    do_reset();
    send_frame(6, 0, DEPTH_A, 0);
    chk("t2_level_rewind", a_level, 0);
    chk("t2_drop_now", a_drop_cnt, 1);
    send_frame(4, 1, DEPTH_A, 0);
    wait_drain(200);
    chk_a_counts("t2");

    // Oversize frame on the 16-deep instance with the sink stalled
    do_reset();
    sel_b = 1'b1;
    b_tready = 1'b0;
    exp_drop++;  // a 20-beat frame cannot fit in 16 entries
    for (int i = 0; i < 20; i++) begin
      send_beat({$urandom, $urandom}, {KW{1'b1}}, i == 19, 1'b1);
      if (i == 15) chk("t3_level_full", b_level, DEPTH_B);
      if (i == 16) chk("t3_level_ovf", b_level, 0);
    end
    chk("t3_drop_now", b_drop_cnt, exp_drop);
    chk("t3_vld_stalled", b_tvalid, 1'b0);
    send_frame(3, 1, DEPTH_B, 0);
    chk("t3_pkt_now", b_pkt_cnt, exp_pkt);
    idle(4);
    b_tready = 1'b1;
    repeat (40) begin
      @(negedge clk156);
      if (b_tvalid) begin
        if (exp_q.size() == 0) chk("t3_spurious", 1'b1, 1'b0);
        else chk("t3_beat", {b_tlast, b_tkeep, b_tdata}, exp_q.pop_front());
      end
    end
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_drop", b_drop_cnt, 1);
    chk("t3_pkt", b_pkt_cnt, 1);
    chk("t3_level", b_level, 0);
    idle(1);
    sel_b = 1'b0;

    // 200 random good frames with random tready and random input gaps
    do_reset();
    rnd_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 40);
      guard = 0;
      while (exp_q.size() + len > DEPTH_A && guard < 5000) begin
        idle(1);
        guard++;
      end
      if (guard >= 5000) chk("t4_flow_wait", guard, 0);
      send_frame(len, 1, DEPTH_A, 1);
      idle($urandom_range(0, 2));
    end
    wait_drain(20000);
    rnd_rdy = 1'b0;
    rdy_fix = 1'b1;
    chk("t4_pkt_200", a_pkt_cnt, 200);
    chk_a_counts("t4");

    // Reset released partway through a frame
    eth_rst = 1'b1;
    exp_q.delete();
    acc_cyc.delete();
    exp_pkt = 0;
    exp_drop = 0;
    send_beat({$urandom, $urandom}, {KW{1'b1}}, 1'b0, 1'b1);
    send_beat({$urandom, $urandom}, {KW{1'b1}}, 1'b0, 1'b1);
    eth_rst = 1'b0;
    for (int i = 2; i < 6; i++) send_beat({$urandom, $urandom}, {KW{1'b1}}, i == 5, 1'b1);
    chk("t5_partial_pkt", a_pkt_cnt, 0);
    chk("t5_partial_drop", a_drop_cnt, 0);
    idle(2);
    send_frame(2, 1, DEPTH_A, 0);
    wait_drain(200);
    chk_a_counts("t5");

    // Reset while the output is showing beat 2 of 5
    do_reset();
    rdy_fix = 1'b0;
    send_frame(5, 1, DEPTH_A, 0);
    guard = 0;
    while (!a_tvalid && guard < 50) begin
      idle(1);
      guard++;
    end
    chk("t6_vld_seen", a_tvalid, 1'b1);
    rdy_fix = 1'b1;
    idle(1);
    rdy_fix = 1'b0;
    chk("t6_pre_vld", a_tvalid, 1'b1);
    chk("t6_remaining", exp_q.size(), 4);
    if (exp_q.size() > 0) chk("t6_pre_beat", {a_tlast, a_tkeep, a_tdata}, exp_q[0]);
    #2;
    eth_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_vld", a_tvalid, 1'b0);
    chk("t6_rst_level", a_level, 0);
    chk("t6_rst_data", a_tdata, 0);
    chk("t6_rst_pkt", a_pkt_cnt, 0);
    rdy_fix = 1'b1;
    do_reset();
    idle(5);
    chk("t6_after_vld", a_tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "time limit");
  end

endmodule
